sdram_port_arbiter: RTL

Round-robin arbiter that shares the single SDRAM controller request port among NUM_PORTS requesters (CPU, video fetch, DMA). It sits directly in front of the SDRAM controller. It forwards one 32-bit word access at a time using 24-bit word addresses (64 MB of 32-bit words). It routes in-order read data back to the requester that issued each read, tracked with a small tag FIFO.

---
 rtl/sdram_pkg.sv | 21 ++
 rtl/sdram_port_arbiter_if.sv | 40 ++++
 rtl/sdram_tag_fifo.sv | 54 +++++
 rtl/sdram_port_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM request types and widths.
// Used by the port arbiter, its interface and tag FIFO.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_BE_W   = 4;

  typedef struct packed {
    logic                    we;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] wdata;
    logic [SDRAM_BE_W-1:0]   be;
  } sdram_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and controller-side bus of the SDRAM port arbiter.
// slave = arbiter view, master = environment view.
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  import sdram_pkg::*;

  logic [NUM_PORTS-1:0]              p_req;
  logic [NUM_PORTS-1:0]              p_we;
  logic [NUM_PORTS*SDRAM_ADDR_W-1:0] p_addr;
  logic [NUM_PORTS*SDRAM_DATA_W-1:0] p_wdata;
  logic [NUM_PORTS*SDRAM_BE_W-1:0]   p_be;
  logic [NUM_PORTS-1:0]              p_gnt;
  logic [NUM_PORTS-1:0]              p_rvalid;
  logic [SDRAM_DATA_W-1:0]           p_rdata;

  logic                    c_req;
  logic                    c_we;
  logic [SDRAM_ADDR_W-1:0] c_addr;
  logic [SDRAM_DATA_W-1:0] c_wdata;
  logic [SDRAM_BE_W-1:0]   c_be;
  logic                    c_ack;
  logic                    c_rvalid;
  logic [SDRAM_DATA_W-1:0] c_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, p_be,
    input  c_ack, c_rvalid, c_rdata,
    output p_gnt, p_rvalid, p_rdata,
    output c_req, c_we, c_addr, c_wdata, c_be
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, p_be,
    output c_ack, c_rvalid, c_rdata,
    input  p_gnt, p_rvalid, p_rdata,
    input  c_req, c_we, c_addr, c_wdata, c_be
  );

endinterface

// File: rtl/sdram_tag_fifo.sv
// FIFO of requester indices for outstanding reads.
// Pop on empty is ignored; push on full only succeeds with a pop.
module sdram_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_tag,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_tag;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port,
// with in-order read data routed back via a tag FIFO.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int RD_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_port_arbiter_if.slave  bus,
  output logic                 err
);

  localparam int TW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(RD_DEPTH) + 1;

  arb_state_t              r_state;
  logic [TW-1:0]           r_ptr;
  sdram_req_t              r_c;
  logic                    r_creq;
  logic [NUM_PORTS-1:0]    r_gnt;
  logic [NUM_PORTS-1:0]    r_rvalid;
  logic [SDRAM_DATA_W-1:0] r_rdata;
  logic                    r_err;

  logic [NUM_PORTS-1:0]    w_elig;
  logic [NUM_PORTS-1:0]    w_win_oh;
  logic [NUM_PORTS-1:0]    w_head_oh;
  logic [TW-1:0]           w_win;
  logic [TW-1:0]           w_head;
  sdram_req_t              w_sel;
  logic                    w_rd_ok;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [CW-1:0]           w_count;

  // First eligible port strictly after ptr, wrapping around.
  function automatic logic [TW-1:0] rr_pick(
    input logic [NUM_PORTS-1:0] elig,
    input logic [TW-1:0]        ptr
  );
    logic [TW-1:0] win;
    logic          hit;
    int            idx;
    win = ptr;
    hit = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (!hit && elig[idx]) begin
        win = TW'(idx);
        hit = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_rd_ok = (w_count < CW'(RD_DEPTH));
  assign w_pop   = bus.c_rvalid && !w_empty;
  assign w_push  = (r_state == ST_ISSUE) && bus.c_ack && !r_c.we
                   && (!w_full || w_pop);

  always_comb begin
    w_elig    = '0;
    w_win_oh  = '0;
    w_head_oh = '0;
    w_sel     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = bus.p_req[i] && (bus.p_we[i] || w_rd_ok);
    end
    w_win = rr_pick(w_elig, r_ptr);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_win == TW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_sel.we    = bus.p_we[i];
        w_sel.addr  = bus.p_addr[i*SDRAM_ADDR_W +: SDRAM_ADDR_W];
        w_sel.wdata = bus.p_wdata[i*SDRAM_DATA_W +: SDRAM_DATA_W];
        w_sel.be    = bus.p_be[i*SDRAM_BE_W +: SDRAM_BE_W];
      end
      if (w_head == TW'(i)) w_head_oh[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= TW'(NUM_PORTS - 1);
      r_c     <= '0;
      r_creq  <= 1'b0;
      r_gnt   <= '0;
    end else begin
      r_gnt <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_c     <= w_sel;
            r_creq  <= 1'b1;
            r_gnt   <= w_win_oh;
            r_ptr   <= w_win;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.c_ack) begin
            r_creq  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_pop ? w_head_oh : '0;
      if (w_pop) r_rdata <= bus.c_rdata;
      if (bus.c_rvalid && w_empty) r_err <= 1'b1;
    end
  end

  sdram_tag_fifo #(
    .DEPTH (RD_DEPTH),
    .W     (TW)
  ) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_tag   (r_ptr),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.p_gnt    = r_gnt;
  assign bus.p_rvalid = r_rvalid;
  assign bus.p_rdata  = r_rdata;
  assign bus.c_req    = r_creq;
  assign bus.c_we     = r_c.we;
  assign bus.c_addr   = r_c.addr;
  assign bus.c_wdata  = r_c.wdata;
  assign bus.c_be     = r_c.be;
  assign err          = r_err;

endmodule
